// File: rtl/ad_fifo_pkg.sv
// Shared helpers for the ADC sample-packing FIFO: width/depth derivation
// and the layout of one stored memory entry.
package ad_fifo_pkg;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int clog2(input int value);
    int r;
    for (r = 0; (1 << r) < value; r++) begin
    end
    return r;
  endfunction

  // Packed word width for a given sample width and pack factor.
  function automatic int wsize_of(input int dsize, input int pack);
    return dsize * pack;
  endfunction

  // Number of buffer entries for a given address width.
  function automatic int depth_of(input int asize);
    return 1 << asize;
  endfunction

  // Each memory entry is {word, tag}; the partial-word tag sits in bit 0.
  localparam int TAG_BIT = 0;

endpackage

// File: rtl/ad_sample_packer.sv
// Collects PACK consecutive samples into one word (first sample in the MSBs)
// and emits a push when the word completes or when a flush forces out a
// partial word, left-justified and tagged.
module ad_sample_packer
  import ad_fifo_pkg::*;
#(
  parameter int DSIZE = 10,
  parameter int PACK  = 2,
  localparam int WSIZE = wsize_of(DSIZE, PACK)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wreq,
  input  logic [DSIZE-1:0] wdata,
  input  logic             flush,
  output logic             push,
  output logic [WSIZE-1:0] push_word,
  output logic             push_tag
);

  // Counter is wide enough to hold PACK itself (samples including this cycle).
  localparam int CW = clog2(PACK + 1);
  localparam logic [CW-1:0] PACK_C = CW'(PACK);
  localparam logic [CW-1:0] LAST_C = CW'(PACK - 1);

  logic [CW-1:0]    pcnt_reg, pcnt_next;
  logic [CW-1:0]    cnt, free;
  logic [WSIZE-1:0] word_reg, word_next;
  logic [WSIZE-1:0] shifted, word_cur;

  // With a single sample per word there is nothing older to keep.
  generate
    if (PACK == 1) begin : g_single
      assign shifted = wdata;
    end else begin : g_multi
      assign shifted = {word_reg[WSIZE-DSIZE-1:0], wdata};
    end
  endgenerate

  // Next-state and push decode; a completing sample wins over flush.
  always_comb begin
    word_cur  = wreq ? shifted : word_reg;
    cnt       = pcnt_reg + CW'(wreq);
    free      = PACK_C - cnt;
    push      = 1'b0;
    push_tag  = 1'b0;
    push_word = word_cur;
    pcnt_next = cnt;
    word_next = word_cur;
    if (wreq && (pcnt_reg == LAST_C)) begin
      push      = 1'b1;
      pcnt_next = '0;
      word_next = '0;
    end else if (flush && (cnt != '0)) begin
      // Samples sit in the low slots; move them up to the MSB end.
      push      = 1'b1;
      push_tag  = 1'b1;
      pcnt_next = '0;
      word_next = '0;
      for (int i = 0; i < PACK; i++) begin
        if (CW'(i) < free) begin
          push_word = push_word << DSIZE;
        end
      end
    end
  end

  // Pack counter and shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_reg <= '0;
      word_reg <= '0;
    end else begin
      pcnt_reg <= pcnt_next;
      word_reg <= word_next;
    end
  end

endmodule

// File: rtl/ad_pack_fifo.sv
// Single-clock ADC sample-packing FIFO: packer front end feeding a
// DEPTH-entry word buffer with registered read, fill level and flags.
module ad_pack_fifo
  import ad_fifo_pkg::*;
#(
  parameter int DSIZE = 10,
  parameter int PACK  = 2,
  parameter int ASIZE = 4,
  parameter int AFULL = 12,
  localparam int WSIZE = wsize_of(DSIZE, PACK),
  localparam int DEPTH = depth_of(ASIZE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wreq,
  input  logic [DSIZE-1:0] wdata,
  input  logic             flush,
  input  logic             ovf_clr,
  input  logic             rreq,
  output logic [WSIZE-1:0] rdata,
  output logic             rvalid,
  output logic             rpartial,
  output logic             empty,
  output logic             full,
  output logic             almost_full,
  output logic [ASIZE:0]   level,
  output logic             overflow
);

  localparam logic [ASIZE:0] DEPTH_L = (ASIZE + 1)'(DEPTH);
  localparam logic [ASIZE:0] AFULL_L = (ASIZE + 1)'(AFULL);

  logic             push;
  logic [WSIZE-1:0] push_word;
  logic             push_tag;
  logic [WSIZE:0]   entry;

  logic [WSIZE:0]   mem [DEPTH];
  logic [ASIZE-1:0] wptr_reg, rptr_reg;
  logic [ASIZE:0]   level_reg, level_next;
  logic             empty_reg, full_reg, afull_reg, ovf_reg;
  logic [WSIZE-1:0] rdata_reg;
  logic             rvalid_reg, rpartial_reg;
  logic             do_push, do_pop;

  ad_sample_packer #(
    .DSIZE (DSIZE),
    .PACK  (PACK)
  ) u_packer (
    .clk       (clk),
    .rst       (rst),
    .wreq      (wreq),
    .wdata     (wdata),
    .flush     (flush),
    .push      (push),
    .push_word (push_word),
    .push_tag  (push_tag)
  );

  // A pop in the same cycle never makes room for a push into a full buffer.
  assign do_push = push && !full_reg;
  assign do_pop  = rreq && !empty_reg;
  assign entry   = {push_word, push_tag};

  // Level after this edge; flags are all derived from it so they agree.
  always_comb begin
    level_next = level_reg + (ASIZE + 1)'(do_push) - (ASIZE + 1)'(do_pop);
  end

  // Word storage write port (no reset so it maps onto block RAM).
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr_reg] <= entry;
    end
  end

  // Registered read port; rdata/rpartial hold when nothing is popped.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_reg    <= '0;
      rpartial_reg <= 1'b0;
      rvalid_reg   <= 1'b0;
    end else begin
      rvalid_reg <= do_pop;
      if (do_pop) begin
        rdata_reg    <= mem[rptr_reg][WSIZE:TAG_BIT+1];
        rpartial_reg <= mem[rptr_reg][TAG_BIT];
      end
    end
  end

  // Pointers, level, status flags and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      level_reg <= '0;
      empty_reg <= 1'b1;
      full_reg  <= 1'b0;
      afull_reg <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      if (do_push) wptr_reg <= wptr_reg + 1'b1;
      if (do_pop)  rptr_reg <= rptr_reg + 1'b1;
      level_reg <= level_next;
      empty_reg <= (level_next == '0);
      full_reg  <= (level_next == DEPTH_L);
      afull_reg <= (level_next >= AFULL_L);
      if (push && full_reg) begin
        ovf_reg <= 1'b1;
      end else if (ovf_clr) begin
        ovf_reg <= 1'b0;
      end
    end
  end

  assign rdata       = rdata_reg;
  assign rvalid      = rvalid_reg;
  assign rpartial    = rpartial_reg;
  assign empty       = empty_reg;
  assign full        = full_reg;
  assign almost_full = afull_reg;
  assign level       = level_reg;
  assign overflow    = ovf_reg;

endmodule

// File: tb/tb_ad_pack_fifo.sv
// Randomised scoreboard bench for ad_pack_fifo with directed scenarios first.
module tb_ad_pack_fifo;

  localparam int DSIZE = 10;
  localparam int PACK  = 2;
  localparam int ASIZE = 4;
  localparam int AFULL = 12;
  localparam int WSIZE = DSIZE * PACK;
  localparam int DEPTH = 1 << ASIZE;

  logic             clk = 1'b0;
  logic             rst;
  logic             wreq;
  logic [DSIZE-1:0] wdata;
  logic             flush;
  logic             ovf_clr;
  logic             rreq;
  logic [WSIZE-1:0] rdata;
  logic             rvalid;
  logic             rpartial;
  logic             empty;
  logic             full;
  logic             almost_full;
  logic [ASIZE:0]   level;
  logic             overflow;

  ad_pack_fifo #(
    .DSIZE (DSIZE),
    .PACK  (PACK),
    .ASIZE (ASIZE),
    .AFULL (AFULL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wreq        (wreq),
    .wdata       (wdata),
    .flush       (flush),
    .ovf_clr     (ovf_clr),
    .rreq        (rreq),
    .rdata       (rdata),
    .rvalid      (rvalid),
    .rpartial    (rpartial),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .level       (level),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  // Reference model: samples waiting to be packed, stored words {word,tag},
  // and the scoreboard of words the DUT is expected to present.
  logic [DSIZE-1:0] pend [$];
  logic [WSIZE:0]   mq [$];
  logic [WSIZE:0]   sb [$];
  logic [WSIZE-1:0] m_rdata;
  logic             m_rpartial;
  logic             m_ovf;
  logic             exp_rvalid;
  bit               mon_en = 0;
  int               n_checks = 0;
  int               n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    mq.delete();
    sb.delete();
    m_rdata    = '0;
    m_rpartial = 1'b0;
    m_ovf      = 1'b0;
    exp_rvalid = 1'b0;
  endtask

  // One clock edge of the model, decided on the state before the edge.
  task automatic model_step();
    bit             pop_ok, was_full, made;
    logic [WSIZE-1:0] w;
    logic [WSIZE:0] ent, popped;
    pop_ok   = rreq && (mq.size() > 0);
    was_full = (mq.size() == DEPTH);
    made     = 0;
    ent      = '0;
    if (wreq) pend.push_back(wdata);
    if ((pend.size() == PACK) || (flush && (pend.size() > 0))) begin
      w = '0;
      for (int i = 0; i < pend.size(); i++) begin
        w = w | (WSIZE'(pend[i]) << ((PACK - 1 - i) * DSIZE));
      end
      ent  = {w, (pend.size() < PACK)};
      made = 1;
      pend.delete();
    end
    exp_rvalid = pop_ok;
    if (pop_ok) begin
      popped     = mq.pop_front();
      sb.push_back(popped);
      m_rdata    = popped[WSIZE:1];
      m_rpartial = popped[0];
    end
    if (made && was_full) m_ovf = 1'b1;
    else if (ovf_clr) m_ovf = 1'b0;
    if (made && !was_full) mq.push_back(ent);
  endtask

  task automatic do_cycle(input bit r, input bit w, input logic [DSIZE-1:0] d,
                          input bit f, input bit rd, input bit oc);
    rst     = r;
    wreq    = w;
    wdata   = d;
    flush   = f;
    rreq    = rd;
    ovf_clr = oc;
    @(posedge clk);
    if (r) model_reset();
    else model_step();
    mon_en = 1;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(0, 0, '0, 0, 0, 0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a word, and
  // compares the status outputs with the model every cycle.
  always @(negedge clk) begin
    logic [WSIZE:0] e;
    if (mon_en) begin
      check("rvalid", 32'(rvalid), 32'(exp_rvalid));
      if (rvalid) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL sb_underflow: got rdata 0x%0h expected no word at %0t", rdata, $time);
        end else begin
          e = sb.pop_front();
          $display("pop rdata=0x%05h rpartial=%0d level=%0d", rdata, rpartial, level);
          check("rdata", 32'(rdata), 32'(e[WSIZE:1]));
          check("rpartial", 32'(rpartial), 32'(e[0]));
        end
      end
      check("rdata_hold", 32'(rdata), 32'(m_rdata));
      check("rpartial_hold", 32'(rpartial), 32'(m_rpartial));
      check("level", 32'(level), 32'(mq.size()));
      check("empty", 32'(empty), 32'(mq.size() == 0));
      check("full", 32'(full), 32'(mq.size() == DEPTH));
      check("almost_full", 32'(almost_full), 32'(mq.size() >= AFULL));
      check("overflow", 32'(overflow), 32'(m_ovf));
    end
  end

  initial begin
    rst = 1'b1; wreq = 1'b0; wdata = '0; flush = 1'b0; rreq = 1'b0; ovf_clr = 1'b0;
    model_reset();
    do_cycle(1, 0, '0, 0, 0, 0);
    do_cycle(1, 0, '0, 0, 0, 0);
    idle(1);

    // Four samples -> two words, then read both.
    for (int i = 1; i <= 4; i++) do_cycle(0, 1, DSIZE'(i), 0, 0, 0);
    do_cycle(0, 0, '0, 0, 1, 0);
    do_cycle(0, 0, '0, 0, 1, 0);
    idle(2);

    // Partial word via flush, then a no-op flush, then read it.
    do_cycle(0, 1, 10'h3FF, 0, 0, 0);
    do_cycle(0, 0, '0, 1, 0, 0);
    do_cycle(0, 0, '0, 1, 0, 0);
    do_cycle(0, 0, '0, 0, 1, 0);
    idle(1);

    // Fill past full with 34 samples, then clear overflow.
    for (int i = 0; i < 34; i++) do_cycle(0, 1, DSIZE'($urandom), 0, 0, 0);
    do_cycle(0, 0, '0, 0, 0, 1);
    // Push and pop together while full: push dropped, pop proceeds.
    do_cycle(0, 1, DSIZE'($urandom), 0, 0, 0);
    do_cycle(0, 1, DSIZE'($urandom), 0, 1, 0);
    // Drain to level 5, then push+pop together.
    for (int i = 0; i < 10; i++) do_cycle(0, 0, '0, 0, 1, 0);
    do_cycle(0, 1, DSIZE'($urandom), 0, 0, 0);
    do_cycle(0, 1, DSIZE'($urandom), 0, 1, 0);
    // Drain fully, then read while empty.
    for (int i = 0; i < 7; i++) do_cycle(0, 0, '0, 0, 1, 0);
    // Push into empty with a read in the same cycle, then read next cycle.
    do_cycle(0, 1, 10'h155, 0, 0, 0);
    do_cycle(0, 1, 10'h2AA, 0, 1, 0);
    do_cycle(0, 0, '0, 0, 1, 0);
    idle(1);

    // Level 7 with one pending sample, then reset mid-operation.
    for (int i = 0; i < 15; i++) do_cycle(0, 1, DSIZE'($urandom), 0, 0, 0);
    do_cycle(1, 0, '0, 0, 0, 0);
    do_cycle(0, 1, 10'h0AB, 0, 0, 0);
    do_cycle(0, 1, 10'h0CD, 0, 0, 0);
    do_cycle(0, 0, '0, 0, 1, 0);
    idle(1);

    // Randomised traffic with occasional flush, clear and reset.
    for (int i = 0; i < 3000; i++) begin
      do_cycle(($urandom_range(0, 399) == 0),
               ($urandom_range(0, 99) < 60),
               DSIZE'($urandom),
               ($urandom_range(0, 99) < 6),
               ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 35 : 65)),
               ($urandom_range(0, 99) < 3));
    end
    idle(3);
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_checks++;
      n_err++;
      $display("FAIL sb_leftover: got %0d unconsumed words expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
